// File: rtl/vc_output_scheduler_pkg.sv
// Shared flit-format constants, flit type codes and lock FSM states for the
// VC output scheduler.
package vc_output_scheduler_pkg;

  localparam int FLIT_WIDTH       = 16;
  localparam int FLIT_TYPE_MSB    = 15;
  localparam int FLIT_TYPE_LSB    = 14;
  localparam int BUFFERSIZE       = 4;
  localparam int BUFFERSIZE_WIDTH = 3;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_t;

  function automatic flit_type_t flit_type(input logic [FLIT_WIDTH-1:0] flit);
    return flit_type_t'(flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
  endfunction

endpackage

// File: rtl/vc_output_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from rr_ptr+1 upward (wrapping)
// and grants the first requester; the pointer register lives in the caller.
module vc_output_scheduler_rr_arbiter #(
  parameter int P_NUM_VC   = 4,
  parameter int P_VC_WIDTH = 2
) (
  input  logic [P_NUM_VC-1:0]   req,
  input  logic [P_VC_WIDTH-1:0] rr_ptr,
  output logic [P_NUM_VC-1:0]   grant,
  output logic [P_VC_WIDTH-1:0] grant_idx
);

  logic [P_VC_WIDTH-1:0] idx;

  // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int off = P_NUM_VC; off >= 1; off--) begin
      idx = rr_ptr + P_VC_WIDTH'(off);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/vc_output_scheduler.sv
// Output-port scheduler: round-robin over VC buffers with downstream credits,
// registered link output. Define PACKET_LOCK_EN for wormhole HEAD..TAIL locking.
module vc_output_scheduler
  import vc_output_scheduler_pkg::*;
#(
  parameter int P_NUM_VC     = 4,
  parameter int P_VC_WIDTH   = 2,
  parameter int P_DATA_WIDTH = FLIT_WIDTH,
  parameter int P_DS_DEPTH   = BUFFERSIZE
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [P_NUM_VC*BUFFERSIZE_WIDTH-1:0] vc_credit_level,
  input  logic [P_NUM_VC*P_DATA_WIDTH-1:0]   vc_data,
  output logic [P_NUM_VC-1:0]                vc_read,
  output logic                               out_valid,
  output logic [P_DATA_WIDTH-1:0]            out_data,
  output logic [P_VC_WIDTH-1:0]              out_vc,
  input  logic                               credit_ret_valid,
  input  logic [P_VC_WIDTH-1:0]              credit_ret_vc
);

  localparam int CW = BUFFERSIZE_WIDTH + 1;
  localparam logic [CW-1:0] DS_FULL = CW'(P_DS_DEPTH);

  logic [CW-1:0]           ds_credit [P_NUM_VC];
  logic [P_VC_WIDTH-1:0]   rr_ptr;
  logic [P_NUM_VC-1:0]     eligible, req, grant, cred_inc;
  logic [P_VC_WIDTH-1:0]   grant_idx;
  logic                    grant_valid, ptr_update;
  logic [P_DATA_WIDTH-1:0] grant_data;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < P_NUM_VC; i++) begin
      eligible[i] = (vc_credit_level[i*BUFFERSIZE_WIDTH +: BUFFERSIZE_WIDTH]
                     != BUFFERSIZE_WIDTH'(BUFFERSIZE)) && (ds_credit[i] != '0);
    end
  end

`ifdef PACKET_LOCK_EN
  lock_state_t           lock_state;
  logic [P_VC_WIDTH-1:0] lock_vc;
  flit_type_t            grant_type;

  assign grant_type = flit_type(grant_data[FLIT_WIDTH-1:0]);
  assign req        = (lock_state == LOCKED) ? (eligible & (P_NUM_VC'(1) << lock_vc)) : eligible;
  // While locked only lock_vc can win, so a TAIL grant there is the packet end.
  assign ptr_update = (lock_state == IDLE) || (grant_type == TAIL);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lock_state <= IDLE;
      lock_vc    <= '0;
    end else if (grant_valid) begin
      case (lock_state)
        IDLE: begin
          if (grant_type == HEAD) begin
            lock_state <= LOCKED;
            lock_vc    <= grant_idx;
          end
        end
        LOCKED: begin
          if (grant_type == TAIL) lock_state <= IDLE;
        end
        default: lock_state <= IDLE;
      endcase
    end
  end
`else
  assign req        = eligible;
  assign ptr_update = 1'b1;
`endif

  vc_output_scheduler_rr_arbiter #(
    .P_NUM_VC  (P_NUM_VC),
    .P_VC_WIDTH(P_VC_WIDTH)
  ) u_arb (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // The read strobe is gated by reset so it drops as soon as reset asserts.
  assign vc_read     = grant & {P_NUM_VC{RST}};
  assign grant_valid = |grant;
  assign grant_data  = vc_data[int'(grant_idx)*P_DATA_WIDTH +: P_DATA_WIDTH];

  always_comb begin
    cred_inc = '0;
    if (credit_ret_valid) cred_inc[credit_ret_vc] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_vc    <= '0;
      rr_ptr    <= P_VC_WIDTH'(P_NUM_VC - 1);
    end else begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= grant_data;
        out_vc   <= grant_idx;
        if (ptr_update) rr_ptr <= grant_idx;
      end
    end
  end

  // A simultaneous grant and return cancel; returns beyond full depth are dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < P_NUM_VC; i++) ds_credit[i] <= DS_FULL;
    end else begin
      for (int i = 0; i < P_NUM_VC; i++) begin
        if (grant[i] && !cred_inc[i])
          ds_credit[i] <= ds_credit[i] - 1'b1;
        else if (cred_inc[i] && !grant[i] && ds_credit[i] != DS_FULL)
          ds_credit[i] <= ds_credit[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Self-checking bench for vc_output_scheduler: bench-side VC FIFOs feed the DUT,
// expected link flits are queued up front and compared as they appear.
module tb_vc_output_scheduler;
  import vc_output_scheduler_pkg::*;

  localparam int NV = 4;
  localparam int DW = FLIT_WIDTH;
  localparam int BW = BUFFERSIZE_WIDTH;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [NV*BW-1:0] vc_credit_level;
  logic [NV*DW-1:0] vc_data;
  logic [NV-1:0] vc_read;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_vc;
  logic          credit_ret_valid = 1'b0;
  logic [1:0]    credit_ret_vc = 2'd0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fifo [NV][$];
  logic [DW-1:0] sb [$];
  logic [NV-1:0] rd;

  vc_output_scheduler dut (
    .CLK             (CLK),
    .RST             (RST),
    .vc_credit_level (vc_credit_level),
    .vc_data         (vc_data),
    .vc_read         (vc_read),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_vc          (out_vc),
    .credit_ret_valid(credit_ret_valid),
    .credit_ret_vc   (credit_ret_vc)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] mk(input flit_type_t t, input int vc, input int seq);
    return {t, 2'(vc), 12'(seq)};
  endfunction

  task automatic refresh();
    for (int i = 0; i < NV; i++) begin
      vc_credit_level[i*BW +: BW] = (fifo[i].size() >= BUFFERSIZE) ? '0 : BW'(BUFFERSIZE - fifo[i].size());
      vc_data[i*DW +: DW]         = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic expect_flit(input int vc, input flit_type_t t, input int seq);
    sb.push_back(mk(t, vc, seq));
  endtask

  task automatic add_flit(input int vc, input flit_type_t t, input int seq, input bit exp);
    fifo[vc].push_back(mk(t, vc, seq));
    if (exp) expect_flit(vc, t, seq);
    refresh();
  endtask

  // One clock: check the read strobe mid-cycle, pop what was read, then check the link.
  task automatic applyStimulus(input logic [NV-1:0] exp_rd, input string tag);
    logic [DW-1:0] f;
    @(negedge CLK);
    rd = vc_read;
    checkOutput({tag, "_rd"}, 32'(rd), 32'(exp_rd));
    @(posedge CLK);
    #1;
    credit_ret_valid = 1'b0;
    for (int i = 0; i < NV; i++)
      if (rd[i] && fifo[i].size() != 0) f = fifo[i].pop_front();
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(|exp_rd));
    if (out_valid) begin
      if (sb.size() == 0) checkOutput({tag, "_sb"}, 32'd1, 32'd0);
      else begin
        f = sb.pop_front();
        checkOutput({tag, "_data"}, 32'(out_data), 32'(f));
        checkOutput({tag, "_vc"}, 32'(out_vc), 32'(f[13:12]));
      end
    end
    refresh();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    credit_ret_valid = 1'b0;
    for (int i = 0; i < NV; i++) fifo[i].delete();
    refresh();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  initial begin
    refresh();
    // Reset state and first grants: one SINGLE per VC, VC0 first, no bubbles.
    for (int v = 0; v < NV; v++) add_flit(v, SINGLE, v, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_rd", 32'(vc_read), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_vc", 32'(out_vc), 32'd0);
    RST = 1'b1;
    applyStimulus(4'b0001, "t1a");
    applyStimulus(4'b0010, "t1b");
    applyStimulus(4'b0100, "t1c");
    applyStimulus(4'b1000, "t1d");
    applyStimulus(4'b0000, "t1e");

    // Credit exhaustion on VC2, then one returned credit releases one flit.
    do_reset();
    for (int k = 0; k < 6; k++) add_flit(2, SINGLE, k, k < 5);
    for (int k = 0; k < 4; k++) applyStimulus(4'b0100, "t2run");
    applyStimulus(4'b0000, "t2dry0");
    applyStimulus(4'b0000, "t2dry1");
    credit_ret_valid = 1'b1;
    credit_ret_vc    = 2'd2;
    applyStimulus(4'b0000, "t2ret");
    applyStimulus(4'b0100, "t2one");
    applyStimulus(4'b0000, "t2dry2");

    // Return at full credit saturates; grant plus return leaves VC1 credit unchanged.
    do_reset();
    credit_ret_valid = 1'b1;
    credit_ret_vc    = 2'd1;
    applyStimulus(4'b0000, "t3sat");
    for (int k = 0; k < 6; k++) add_flit(1, SINGLE, k, k < 5);
    credit_ret_valid = 1'b1;
    credit_ret_vc    = 2'd1;
    applyStimulus(4'b0010, "t3both");
    for (int k = 0; k < 4; k++) applyStimulus(4'b0010, "t3run");
    applyStimulus(4'b0000, "t3dry");

    // VC0 packet with a 3-cycle gap before its TAIL while VC1 always has flits.
    do_reset();
    add_flit(0, HEAD, 0, 1'b0);
    add_flit(0, BODY, 1, 1'b0);
    for (int k = 0; k < 4; k++) add_flit(1, BODY, 10 + k, 1'b0);
`ifdef PACKET_LOCK_EN
    expect_flit(0, HEAD, 0);
    expect_flit(0, BODY, 1);
    applyStimulus(4'b0001, "t4head");
    applyStimulus(4'b0001, "t4body");
    for (int k = 0; k < 3; k++) applyStimulus(4'b0000, "t4gap");
    add_flit(0, TAIL, 2, 1'b1);
    for (int k = 0; k < 4; k++) expect_flit(1, BODY, 10 + k);
    applyStimulus(4'b0001, "t4tail");
    for (int k = 0; k < 4; k++) applyStimulus(4'b0010, "t4vc1");
    applyStimulus(4'b0000, "t4end");
`else
    expect_flit(0, HEAD, 0);
    expect_flit(1, BODY, 10);
    expect_flit(0, BODY, 1);
    for (int k = 1; k < 4; k++) expect_flit(1, BODY, 10 + k);
    applyStimulus(4'b0001, "t5a");
    applyStimulus(4'b0010, "t5b");
    applyStimulus(4'b0001, "t5c");
    for (int k = 0; k < 3; k++) applyStimulus(4'b0010, "t5vc1");
    add_flit(0, TAIL, 2, 1'b1);
    applyStimulus(4'b0001, "t5tail");
    applyStimulus(4'b0000, "t5end");
`endif

    // Asynchronous reset in the middle of a VC3 packet.
    do_reset();
    add_flit(3, HEAD, 0, 1'b1);
    add_flit(3, BODY, 1, 1'b1);
    add_flit(3, BODY, 2, 1'b0);
    add_flit(3, TAIL, 3, 1'b0);
    applyStimulus(4'b1000, "t6head");
    applyStimulus(4'b1000, "t6body");
    #2 RST = 1'b0;
    #1;
    checkOutput("t6_rst_rd", 32'(vc_read), 32'd0);
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_vc", 32'(out_vc), 32'd0);
    checkOutput("t6_rst_data", 32'(out_data), 32'd0);
    for (int i = 0; i < NV; i++) fifo[i].delete();
    add_flit(0, SINGLE, 0, 1'b1);
    for (int k = 0; k < 5; k++) add_flit(3, SINGLE, k, k < 4);
    @(posedge CLK);
    #1 RST = 1'b1;
    applyStimulus(4'b0001, "t6vc0");
    for (int k = 0; k < 4; k++) applyStimulus(4'b1000, "t6vc3");
    applyStimulus(4'b0000, "t6dry");

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
